clock_12hr_bcd: RTL and testbench

//   12-hour wall clock: hours, minutes and seconds as packed 2-digit BCD, plus an AM/PM flag.

---
 rtl/clock_12hr_bcd.sv | 93 +++++++++
 tb/tb_clock_12hr_bcd.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/clock_12hr_bcd.sv
// 12-hour wall clock with packed 2-digit BCD outputs and an AM/PM flag.
// Advances by one second on every rising clk edge where ena is high.
//
// Ports:
//   clk    system clock, rising-edge active
//   reset  asynchronous active-high reset to 12:00:00 AM
//   ena    seconds tick; 1 = advance by one second this cycle
//   pm     0 = AM, 1 = PM
//   hh     hours   BCD {tens, ones}, 01..12
//   mm     minutes BCD {tens, ones}, 00..59
//   ss     seconds BCD {tens, ones}, 00..59
module clock_12hr_bcd (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   output logic       pm,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss
);

   logic [7:0] hh_q, hh_d;
   logic [7:0] mm_q, mm_d;
   logic [7:0] ss_q, ss_d;
   logic       pm_q, pm_d;
   logic       sec_carry;
   logic       min_carry;

   // Two-digit BCD increment over 00..59, wrapping 59 -> 00.
   function automatic logic [7:0] inc_0_59(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd5) r = 8'h00;
         else                r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // Two-digit BCD hour increment over 01..12, wrapping 12 -> 01.
   function automatic logic [7:0] inc_hour(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h12)             r = 8'h01;
      else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
      else                        r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // Carries ripple in the same cycle so xx:59:59 rolls over in one edge.
   assign sec_carry = ena && (ss_q == 8'h59);
   assign min_carry = sec_carry && (mm_q == 8'h59);

   always_comb begin
      ss_d = ss_q;
      mm_d = mm_q;
      hh_d = hh_q;
      pm_d = pm_q;
      if (ena) begin
         ss_d = inc_0_59(ss_q);
      end
      if (sec_carry) begin
         mm_d = inc_0_59(mm_q);
      end
      if (min_carry) begin
         hh_d = inc_hour(hh_q);
         // Meridiem flips entering 12 o'clock, not when 12 wraps to 1.
         if (hh_q == 8'h11) begin
            pm_d = ~pm_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hh_q <= 8'h12;
         mm_q <= 8'h00;
         ss_q <= 8'h00;
         pm_q <= 1'b0;
      end else begin
         hh_q <= hh_d;
         mm_q <= mm_d;
         ss_q <= ss_d;
         pm_q <= pm_d;
      end
   end

   assign hh = hh_q;
   assign mm = mm_q;
   assign ss = ss_q;
   assign pm = pm_q;

endmodule

// File: tb/tb_clock_12hr_bcd.sv
// Directed bench for clock_12hr_bcd. Expected times come from a seconds-since-
// midnight model converted to 12-hour BCD.
module tb_clock_12hr_bcd;

   logic       clk;
   logic       reset;
   logic       ena;
   logic       pm;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;

   int checks = 0;
   int errors = 0;
   int t      = 0;   // model time in seconds since 12:00:00 AM

   clock_12hr_bcd dut (
      .clk   (clk),
      .reset (reset),
      .ena   (ena),
      .pm    (pm),
      .hh    (hh),
      .mm    (mm),
      .ss    (ss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   task automatic check(input string tag, input logic [7:0] eh, input logic [7:0] em,
                        input logic [7:0] es, input logic ep);
      checks++;
      assert ({hh, mm, ss, pm} === {eh, em, es, ep}) else begin
         errors++;
         $error("FAIL %s: got %h:%h:%h pm=%b, expected %h:%h:%h pm=%b",
                tag, hh, mm, ss, pm, eh, em, es, ep);
      end
   endtask

   // Compare the DUT against the model time t.
   task automatic check_model(input string tag);
      int s, h24, h12;
      s   = t % 86400;
      h24 = s / 3600;
      h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
      check(tag, to_bcd(h12), to_bcd((s / 60) % 60), to_bcd(s % 60), 1'(h24 >= 12));
   endtask

   task automatic check_legal(input string tag);
      logic ok;
      ok = (ss[3:0] <= 4'd9) && (ss[7:4] <= 4'd5) && (mm[3:0] <= 4'd9) &&
           (mm[7:4] <= 4'd5) && (hh[3:0] <= 4'd9) && (hh[7:4] <= 4'd1) &&
           (hh != 8'h00) && (hh <= 8'h12);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s: illegal BCD value %h:%h:%h", tag, hh, mm, ss);
      end
   endtask

   // Exactly n rising edges with ena high, then ena dropped before the next edge.
   task automatic ticks(input int n);
      if (n > 0) begin
         @(negedge clk);
         ena = 1'b1;
         repeat (n) @(posedge clk);
         #1;
         ena = 1'b0;
         t += n;
      end
   endtask

   task automatic run_to(input int target);
      ticks(target - t);
   endtask

   initial begin
      reset = 1'b1;
      ena   = 1'b0;
      #10;
      check("reset_state", 8'h12, 8'h00, 8'h00, 1'b0);

      // ena toggling while reset is held must not move the time.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ena = ~ena;
         @(posedge clk);
         #1;
         check("reset_hold", 8'h12, 8'h00, 8'h00, 1'b0);
      end
      @(negedge clk);
      ena   = 1'b0;
      reset = 1'b0;

      ticks(1);
      check("first_tick", 8'h12, 8'h00, 8'h01, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("ena_low_hold", 8'h12, 8'h00, 8'h01, 1'b0);

      // Single steps through 09->10 and 59->00 on seconds.
      for (int i = 0; i < 59; i++) begin
         ticks(1);
         check_legal("sec_legal");
         if (t == 10) check("sec_09_10", 8'h12, 8'h00, 8'h10, 1'b0);
      end
      check("minute_carry", 8'h12, 8'h01, 8'h00, 1'b0);

      run_to(3599);
      check("to_12_59_59am", 8'h12, 8'h59, 8'h59, 1'b0);
      ticks(1);
      check("12_to_01_am", 8'h01, 8'h00, 8'h00, 1'b0);

      run_to(9 * 3600 + 3599);
      check("to_09_59_59am", 8'h09, 8'h59, 8'h59, 1'b0);
      ticks(1);
      check("09_to_10", 8'h10, 8'h00, 8'h00, 1'b0);

      run_to(11 * 3600 + 3599);
      check("to_11_59_59am", 8'h11, 8'h59, 8'h59, 1'b0);
      ticks(1);
      check("am_to_pm", 8'h12, 8'h00, 8'h00, 1'b1);

      run_to(12 * 3600 + 3599);
      ticks(1);
      check("12_to_01_pm", 8'h01, 8'h00, 8'h00, 1'b1);

      run_to(15 * 3600 + 27 * 60 + 45);
      check_model("mid_pm_model");

      run_to(86399);
      check("to_11_59_59pm", 8'h11, 8'h59, 8'h59, 1'b1);
      ticks(1);
      check("pm_to_am_wrap", 8'h12, 8'h00, 8'h00, 1'b0);
      check_model("full_period_model");

      // Asynchronous reset mid-cycle while ena is high.
      run_to(86400 + 27 * 60 + 45);
      check("to_12_27_45am", 8'h12, 8'h27, 8'h45, 1'b0);
      @(negedge clk);
      ena = 1'b1;
      @(posedge clk);
      #3;
      check("pre_async_reset", 8'h12, 8'h27, 8'h46, 1'b0);
      reset = 1'b1;
      #1;
      check("async_reset", 8'h12, 8'h00, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check("reset_over_ena", 8'h12, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      ena = 1'b0;
      check("resume_after_reset", 8'h12, 8'h00, 8'h01, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
